instruction_memory_multiport: RTL and testbench
===============================================

INSTRUCTION_MEMORY_MULTIPORT -- requirements
Module: instruction_memory_multiport

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of core fetch ports.
REQ-002 Parameter ADDR_W, default 8: fetch address width.
REQ-003 Parameter DATA_W, default 8: instruction word width.
REQ-004 Parameter DEPTH, default 256: word count; SHALL be <= 2**ADDR_W.
REQ-005 Port clock, input, 1: single clock; all state on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port rd_en, input, NUM_PORTS: per-port fetch request.
REQ-008 Port addr, input, NUM_PORTS*ADDR_W: per-port fetch address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 Port instr, output, NUM_PORTS*DATA_W: per-port fetched word, same packing as addr.
REQ-010 Port instr_valid, output, NUM_PORTS: instr of that port updated this cycle.
REQ-011 Port ld_start, input, 1: begin a program download.
REQ-012 Port ld_valid / ld_ready, input / output, 1 each: download handshake.
REQ-013 Port ld_data, input, DATA_W: download word.
REQ-014 Port ld_last, input, 1: qualifies final download word.
REQ-015 Port loaded, output, 1: program present, fetch enabled.
REQ-016 Port prog_len, output, ADDR_W+1: words in the current program.

Function
REQ-017 FSM states IDLE, LOAD, RUN; reset enters IDLE.
REQ-018 IDLE: ld_start -> LOAD next cycle; write pointer cleared; ld_ready=1 from LOAD entry.
REQ-019 ld_start in LOAD SHALL be ignored; ld_start in RUN SHALL re-enter LOAD (reload); loaded drops the following cycle.
REQ-020 LOAD: each cycle with ld_valid&&ld_ready writes ld_data to mem[wptr], wptr+1.
REQ-021 Accepted word with ld_last, or accepted word at wptr==DEPTH-1, -> RUN; prog_len=wptr+1; ld_ready=0, loaded=1 in the same following cycle.
REQ-022 ld_valid outside LOAD SHALL be ignored; no backpressure gaps in LOAD (ld_ready constant 1).
REQ-023 RUN, rd_en[p]=1: instr[p] <= mem[addr[p]], instr_valid[p] <= 1; latency exactly 1 cycle; all ports independent, same-address reads legal.
REQ-024 RUN, rd_en[p]=1, addr[p] >= prog_len: instr[p] <= OP_END (package constant 38), instr_valid[p] <= 1.
REQ-025 rd_en[p]=0: instr[p] holds last value, instr_valid[p] <= 0 (stall).
REQ-026 IDLE/LOAD: instr_valid all 0, instr holds; rd_en ignored.
REQ-027 Memory contents SHALL NOT be cleared by reset or reload; only written words change.

Reset
REQ-028 reset_n low asynchronously: state IDLE, wptr=0, prog_len=0, loaded=0, ld_ready=0, instr=0, instr_valid=0, par_err=0.
REQ-029 Reset mid-LOAD aborts the download; a new ld_start restarts from address 0.

Configuration
REQ-030 Macro IMEM_PARITY_EN defined: each word stored with one even-parity bit computed at write; extra input ld_par_flip (1) inverts the stored bit for that write; extra output par_err (NUM_PORTS) asserted with instr_valid[p] on mismatch, else 0.
REQ-031 IMEM_PARITY_EN undefined: no parity storage, no ld_par_flip/par_err ports; all else identical.

Structure
REQ-032 Package imem_pkg: opcode constants (RSTALL, LODAC, ..., OP_END=38, JUMNZ=40), FSM state type, default widths.
REQ-033 Sub-module imem_loader: FSM, handshake, wptr, prog_len; storage and read ports stay in top.

Verification
REQ-034 Reset then ld_start, load 5 words 0x08,0x09,0x0B,0x09,0x0C with ld_last on 5th -> loaded=1, prog_len=5, ld_ready=0.
REQ-035 RUN, rd_en=4'b1111, addr={0,1,4,4} -> next cycle instr={0x08,0x09,0x0C,0x0C}, instr_valid=4'b1111.
REQ-036 RUN, addr[2]=200 (>= prog_len) -> instr[2]=38, instr_valid[2]=1; rd_en[1]=0 -> instr[1] holds, instr_valid[1]=0.
REQ-037 Load 256 words without ld_last -> RUN after 256th accept, prog_len=256; ld_valid afterwards ignored.
REQ-038 reset_n low after 3 accepted words -> all outputs at reset values; reload of 2 words -> prog_len=2, addr 2 reads 38.
REQ-039 IMEM_PARITY_EN, word at address 1 written with ld_par_flip=1 -> fetch addr 1 gives par_err[p]=1; addr 0 gives 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the multiport instruction memory.
//   - Default geometry of the memory and its fetch ports.
//   - Opcode constants of the core ISA. OP_END is returned for fetches past the program.
//   - Encoding of the download/run FSM states.
package imem_pkg;

    localparam int unsigned DefNumPorts = 4;
    localparam int unsigned DefAddrW    = 8;
    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefDepth    = 256;

    // Opcodes
    localparam int unsigned RSTALL = 0;
    localparam int unsigned LODAC  = 8;
    localparam int unsigned STRAC  = 9;
    localparam int unsigned ADDAC  = 11;
    localparam int unsigned SUBAC  = 12;
    localparam int unsigned JUMP   = 32;
    localparam int unsigned JUMZ   = 36;
    localparam int unsigned OP_END = 38;
    localparam int unsigned JUMNZ  = 40;

    // FSM state encoding
    typedef logic [1:0] imem_state_t;
    localparam imem_state_t ST_IDLE = 2'd0;
    localparam imem_state_t ST_LOAD = 2'd1;
    localparam imem_state_t ST_RUN  = 2'd2;

endpackage

// File: rtl/imem_loader.sv
// Program download controller for the instruction memory.
// It holds the IDLE/LOAD/RUN FSM, the write pointer and the program length.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   ld_start_i     begin a download. Ignored while loading, and restarts a download from RUN.
//   ld_valid_i     download word offered
//   ld_last_i      marks the offered word as the final word of the program
//   ld_ready_o     high for the whole of LOAD
//   loaded_o       program present, so fetch is enabled
//   wr_en_o        write strobe for the storage
//   wr_addr_o      address for the write strobe
//   prog_len_o     number of words in the current program
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DEPTH  = DefDepth
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ld_start_i,
    input  logic              ld_valid_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              loaded_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W:0]   prog_len_o
);

    imem_state_t       state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        prog_len_d = prog_len_q;
        case (state_q)
            ST_IDLE: begin
                if (ld_start_i) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                end
            end
            ST_LOAD: begin
                if (ld_valid_i) begin
                    wptr_d = wptr_q + 1'b1;
                    // Memory full acts as an implicit last word.
                    if (ld_last_i || (wptr_q == ADDR_W'(DEPTH - 1))) begin
                        state_d    = ST_RUN;
                        prog_len_d = {1'b0, wptr_q} + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (ld_start_i) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            prog_len_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            prog_len_q <= prog_len_d;
        end
    end

    assign ld_ready_o = (state_q == ST_LOAD);
    assign loaded_o   = (state_q == ST_RUN);
    assign wr_en_o    = (state_q == ST_LOAD) && ld_valid_i;
    assign wr_addr_o  = wptr_q;
    assign prog_len_o = prog_len_q;

endmodule

// File: rtl/instruction_memory_multiport.sv
// Instruction memory with one download port and NUM_PORTS independent read ports.
// Each read port has a latency of one cycle.
// Optional feature: when the macro IMEM_PARITY_EN is defined, each word is stored with an
// even-parity bit, and parity errors are reported for each read port.
// Ports:
//   clock, reset_n       clock and asynchronous active-low reset
//   rd_en, addr          per-port fetch request and address. Port p is at [p*ADDR_W +: ADDR_W].
//   instr, instr_valid   per-port fetched word, and a flag that it was updated this cycle
//   ld_start, ld_valid, ld_ready, ld_data, ld_last   program download interface
//   loaded, prog_len     program present, and its length in words
//   ld_par_flip, par_err (IMEM_PARITY_EN only) force a bad parity bit on write, and per-port error
module instruction_memory_multiport
    import imem_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DefNumPorts,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned DEPTH     = DefDepth
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_PORTS-1:0]          rd_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
    output logic [NUM_PORTS*DATA_W-1:0]   instr,
    output logic [NUM_PORTS-1:0]          instr_valid,
    input  logic                          ld_start,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [DATA_W-1:0]             ld_data,
    input  logic                          ld_last,
    output logic                          loaded,
    output logic [ADDR_W:0]               prog_len
`ifdef IMEM_PARITY_EN
    ,
    input  logic                          ld_par_flip,
    output logic [NUM_PORTS-1:0]          par_err
`endif
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    imem_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .ld_start_i (ld_start),
        .ld_valid_i (ld_valid),
        .ld_last_i  (ld_last),
        .ld_ready_o (ld_ready),
        .loaded_o   (loaded),
        .wr_en_o    (wr_en),
        .wr_addr_o  (wr_addr),
        .prog_len_o (prog_len)
    );

    // Storage. It has no reset, so contents survive reset and reload.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= ld_data;
        end
    end

    logic [DATA_W-1:0] rd_word  [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_in_range;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_in_range[p] = {1'b0, addr[p*ADDR_W +: ADDR_W]} < prog_len;
            rd_word[p]     = DATA_W'(OP_END);
            if (rd_in_range[p]) begin
                rd_word[p] = mem[addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    logic [NUM_PORTS*DATA_W-1:0] instr_q;
    logic [NUM_PORTS-1:0]        instr_valid_q;

    // A stalled port keeps its last word but drops valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q       <= '0;
            instr_valid_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (loaded && rd_en[p]) begin
                    instr_q[p*DATA_W +: DATA_W] <= rd_word[p];
                    instr_valid_q[p]            <= 1'b1;
                end else begin
                    instr_valid_q[p]            <= 1'b0;
                end
            end
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

`ifdef IMEM_PARITY_EN
    logic                 mem_par [DEPTH];
    logic [NUM_PORTS-1:0] rd_par_err;
    logic [NUM_PORTS-1:0] par_err_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_par[wr_addr] <= (^ld_data) ^ ld_par_flip;
        end
    end

    // The OP_END substitute is generated locally, so it never reports an error.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_par_err[p] = 1'b0;
            if (rd_in_range[p]) begin
                rd_par_err[p] = (^mem[addr[p*ADDR_W +: ADDR_W]]) ^
                                mem_par[addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_err_q <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                par_err_q[p] <= loaded && rd_en[p] && rd_par_err[p];
            end
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_instruction_memory_multiport.sv
// Directed testbench for instruction_memory_multiport with its default parameters.
module tb_instruction_memory_multiport;

    logic        clock;
    logic        reset_n;
    logic [3:0]  rd_en;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [3:0]  instr_valid;
    logic        ld_start;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        loaded;
    logic [8:0]  prog_len;
`ifdef IMEM_PARITY_EN
    logic        ld_par_flip;
    logic [3:0]  par_err;
`endif

    int errors = 0;
    int checks = 0;

    instruction_memory_multiport dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rd_en       (rd_en),
        .addr        (addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .loaded      (loaded),
        .prog_len    (prog_len)
`ifdef IMEM_PARITY_EN
        ,
        .ld_par_flip (ld_par_flip),
        .par_err     (par_err)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rd_en    = '0;
        addr     = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
`ifdef IMEM_PARITY_EN
        ld_par_flip = 1'b0;
`endif
        #12;
        checks++;
        if ({loaded, ld_ready, prog_len} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got loaded=%b ld_ready=%b prog_len=%0d, expected 0 0 0",
                     loaded, ld_ready, prog_len);
        end
        checks++;
        if ({instr, instr_valid} !== 36'd0) begin
            errors++;
            $display("FAIL reset_instr: got instr=%h valid=%b, expected 0 0", instr, instr_valid);
        end
        reset_n = 1'b1;
        tick();
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b expected 0", ld_ready);
        end
    endtask

    task automatic test_load5();
        logic [7:0] words [5];
        words = '{8'h08, 8'h09, 8'h0B, 8'h09, 8'h0C};
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        checks++;
        if ({ld_ready, loaded} !== 2'b10) begin
            errors++;
            $display("FAIL load_entry: got ld_ready=%b loaded=%b expected 1 0", ld_ready, loaded);
        end
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1;
            ld_data  = words[i];
            ld_last  = (i == 4);
            ld_start = (i == 2);  // must be ignored while loading
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_start = 1'b0;
        checks++;
        if ({loaded, ld_ready, prog_len} !== {1'b1, 1'b0, 9'd5}) begin
            errors++;
            $display("FAIL load5_done: got loaded=%b ld_ready=%b prog_len=%0d expected 1 0 5",
                     loaded, ld_ready, prog_len);
        end
    endtask

    task automatic test_fetch();
        rd_en = 4'b1111;
        addr  = {8'd4, 8'd4, 8'd1, 8'd0};
        tick();
        checks++;
        if (instr !== {8'h0C, 8'h0C, 8'h09, 8'h08}) begin
            errors++;
            $display("FAIL fetch_data: got %h expected 0c0c0908", instr);
        end
        checks++;
        if (instr_valid !== 4'b1111) begin
            errors++;
            $display("FAIL fetch_valid: got %b expected 1111", instr_valid);
        end
    endtask

    task automatic test_out_of_range_stall();
        rd_en = 4'b1101;
        addr  = {8'd2, 8'd200, 8'd0, 8'd3};
        tick();
        checks++;
        if (instr !== {8'h0B, 8'd38, 8'h09, 8'h09}) begin
            errors++;
            $display("FAIL oor_stall_data: got %h expected 0b260909", instr);
        end
        checks++;
        if (instr_valid !== 4'b1101) begin
            errors++;
            $display("FAIL oor_stall_valid: got %b expected 1101", instr_valid);
        end
        // Program boundary: address 4 is the last word, and address 5 is past the end.
        rd_en = 4'b0011;
        addr  = {8'd0, 8'd0, 8'd5, 8'd4};
        tick();
        checks++;
        if (instr !== {8'h0B, 8'd38, 8'd38, 8'h0C} || instr_valid !== 4'b0011) begin
            errors++;
            $display("FAIL boundary: got %h/%b expected 0b26260c/0011", instr, instr_valid);
        end
        rd_en = 4'b0000;
        tick();
        checks++;
        if (instr !== {8'h0B, 8'd38, 8'd38, 8'h0C} || instr_valid !== 4'b0000) begin
            errors++;
            $display("FAIL all_stall: got %h/%b expected 0b26260c/0000", instr, instr_valid);
        end
    endtask

    task automatic test_full_load();
        int ready_drops;
        ready_drops = 0;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        checks++;
        if ({loaded, ld_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reload_entry: got loaded=%b ld_ready=%b expected 0 1", loaded, ld_ready);
        end
        for (int i = 0; i < 256; i++) begin
            if (ld_ready !== 1'b1) ready_drops++;
            ld_valid = 1'b1;
            ld_data  = 8'(i) ^ 8'hA5;
            tick();
        end
        checks++;
        if (ready_drops != 0) begin
            errors++;
            $display("FAIL full_ready_gaps: got %0d cycles without ready, expected 0", ready_drops);
        end
        checks++;
        if ({loaded, ld_ready, prog_len} !== {1'b1, 1'b0, 9'd256}) begin
            errors++;
            $display("FAIL full_done: got loaded=%b ld_ready=%b prog_len=%0d expected 1 0 256",
                     loaded, ld_ready, prog_len);
        end
        // Words offered in RUN must not be written.
        ld_data = 8'hFF;
        tick();
        tick();
        ld_valid = 1'b0;
        rd_en = 4'b1111;
        addr  = {8'd7, 8'd128, 8'd0, 8'd255};
        tick();
        rd_en = 4'b0000;
        checks++;
        if (instr !== {8'hA2, 8'h25, 8'hA5, 8'h5A} || prog_len !== 9'd256) begin
            errors++;
            $display("FAIL full_fetch: got %h len=%0d expected a225a55a len=256", instr, prog_len);
        end
    endtask

    task automatic test_reset_mid_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'h31 + 8'(i);
            tick();
        end
        ld_valid = 1'b0;
        reset_n  = 1'b0;
        #2;
        checks++;
        if ({loaded, ld_ready, prog_len, instr, instr_valid} !== 47'd0) begin
            errors++;
            $display("FAIL mid_reset: got loaded=%b rdy=%b len=%0d instr=%h valid=%b expected 0",
                     loaded, ld_ready, prog_len, instr, instr_valid);
        end
        #2;
        reset_n = 1'b1;
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_data  = (i == 0) ? 8'h11 : 8'h22;
            ld_last  = (i == 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if ({loaded, prog_len} !== {1'b1, 9'd2}) begin
            errors++;
            $display("FAIL reload2_done: got loaded=%b prog_len=%0d expected 1 2", loaded, prog_len);
        end
        rd_en = 4'b1111;
        addr  = {8'd3, 8'd2, 8'd1, 8'd0};
        tick();
        rd_en = 4'b0000;
        checks++;
        if (instr !== {8'd38, 8'd38, 8'h22, 8'h11}) begin
            errors++;
            $display("FAIL reload2_fetch: got %h expected 26262211", instr);
        end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_valid    = 1'b1;
            ld_data     = (i == 0) ? 8'h08 : 8'h09;
            ld_par_flip = (i == 1);
            ld_last     = (i == 1);
            tick();
        end
        ld_valid    = 1'b0;
        ld_par_flip = 1'b0;
        ld_last     = 1'b0;
        rd_en = 4'b1111;
        addr  = {8'd5, 8'd1, 8'd1, 8'd0};
        tick();
        checks++;
        if (par_err !== 4'b0110) begin
            errors++;
            $display("FAIL parity_err: got %b expected 0110", par_err);
        end
        rd_en = 4'b0000;
        tick();
        checks++;
        if (par_err !== 4'b0000) begin
            errors++;
            $display("FAIL parity_stall: got %b expected 0000", par_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load5();
        test_fetch();
        test_out_of_range_stall();
        test_full_load();
        test_reset_mid_load();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
